kb_matrix_emulator: RTL

//  Synthesizable, parametrised keypad-matrix emulator. It replaces ad-hoc key-press tasks in gomoku benches and serves as an on-board self-play driver.
//  - Queues key/OK commands in a FIFO and replays each one as a timed press on the row/column matrix, or as a btn_ok pulse.
//  - Answers the DUT's column scan and sits between the command source and gomoku_main's keyboard_col/keyboard_row/btn_ok pins.

---
 rtl/kb_matrix_emulator_pkg.sv | 22 ++
 rtl/kb_matrix_emulator_if.sv | 12 +
 rtl/kb_matrix_emulator_sync_fifo.sv | 55 +++++
 rtl/kb_matrix_emulator.sv | 125 ++++++++++++
 4 files changed

// File: rtl/kb_matrix_emulator_pkg.sv
// Shared types and active-low decode helpers for the keypad-matrix emulator.
package kb_matrix_emulator_pkg;

    typedef enum logic [1:0] {
        KB_IDLE  = 2'd0,
        KB_PRESS = 2'd1,
        KB_GAP   = 2'd2
    } kb_state_e;

    // Active-low one-hot with MSB = index 0, matching the DUT's scan ordering.
    function automatic logic [31:0] kb_row_onehot_n(input int unsigned idx, input int unsigned n);
        return ~(32'd1 << (n - 1 - idx));
    endfunction

    function automatic logic kb_col_match(input logic [31:0] col, input int unsigned c,
                                          input int unsigned n);
        logic [31:0] mask;
        mask = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
        return ((col ^ kb_row_onehot_n(c, n)) & mask) == '0;
    endfunction

endpackage

// File: rtl/kb_matrix_emulator_if.sv
// Command handshake between the command source and the emulator.
interface kb_matrix_emulator_if #(
    parameter int unsigned CODE_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CODE_W-1:0] cmd_code;
    logic              cmd_is_ok;

    modport master (output cmd_valid, output cmd_code, output cmd_is_ok, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_code, input cmd_is_ok, output cmd_ready);
endinterface

// File: rtl/kb_matrix_emulator_sync_fifo.sv
// Show-ahead synchronous FIFO with level output and synchronous clear.
module sync_fifo #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_wr, do_rd;

    assign do_wr   = wr_en && !full && !clr;
    assign do_rd   = rd_en && !empty && !clr;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/kb_matrix_emulator.sv
// Keypad-matrix emulator: queues key/OK commands and replays them as timed
// presses answering the DUT's active-low column scan.
module kb_matrix_emulator
    import kb_matrix_emulator_pkg::*;
#(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4,
    parameter int unsigned HOLD_CYC   = 50,
    parameter int unsigned GAP_CYC    = 50,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    kb_matrix_emulator_if.slave          cmd_if,
    input  logic                         flush,
    input  logic [COLS-1:0]              keyboard_col,
    output logic [ROWS-1:0]              keyboard_row,
    output logic                         btn_ok,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         err_bad_code
);
    localparam int unsigned NKEYS   = ROWS * COLS;
    localparam int unsigned CODE_W  = $clog2(NKEYS);
    localparam int unsigned CNT_MAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned GAP_LD  = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    kb_state_e         state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [CODE_W-1:0] cur_code, head_code;
    logic              cur_ok, cur_bad, head_ok, head_bad;
    logic              full, empty, push, pop;
    int unsigned       cur_row, cur_col;

    assign cmd_if.cmd_ready = !full && !flush;
    assign push             = cmd_if.cmd_valid && cmd_if.cmd_ready;

    sync_fifo #(
        .WIDTH (CODE_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush),
        .wr_en   (push),
        .wr_data ({cmd_if.cmd_is_ok, cmd_if.cmd_code}),
        .rd_en   (pop),
        .rd_data ({head_ok, head_code}),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    assign head_bad = !head_ok && (32'(head_code) >= NKEYS);
    assign busy     = (state != KB_IDLE) || !empty;
    assign cur_row  = 32'(cur_code) / COLS;
    assign cur_col  = 32'(cur_code) % COLS;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pop     = 1'b0;
        if (flush) begin
            state_n = KB_IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                KB_IDLE: begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = KB_PRESS;
                        cnt_n   = CNT_W'(HOLD_CYC - 1);
                    end
                end
                KB_PRESS, KB_GAP: begin
                    if (cnt != '0) begin
                        cnt_n = cnt - CNT_W'(1);
                    end else if (state == KB_PRESS && GAP_CYC > 0) begin
                        state_n = KB_GAP;
                        cnt_n   = CNT_W'(GAP_LD);
                    end else if (!empty) begin
                        // End of gap (or of press when the gap is zero): chain straight into the next command.
                        pop     = 1'b1;
                        state_n = KB_PRESS;
                        cnt_n   = CNT_W'(HOLD_CYC - 1);
                    end else begin
                        state_n = KB_IDLE;
                    end
                end
                default: state_n = KB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= KB_IDLE;
            cnt          <= '0;
            cur_code     <= '0;
            cur_ok       <= 1'b0;
            cur_bad      <= 1'b0;
            btn_ok       <= 1'b0;
            err_bad_code <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (pop) begin
                cur_code <= head_code;
                cur_ok   <= head_ok;
                cur_bad  <= head_bad;
            end
            btn_ok       <= (state_n == KB_PRESS) && (pop ? head_ok : cur_ok);
            err_bad_code <= pop && head_bad;
        end
    end

    always_comb begin
        keyboard_row = '1;
        if (state == KB_PRESS && !cur_ok && !cur_bad &&
            kb_col_match(32'(keyboard_col), cur_col, COLS))
            keyboard_row = ROWS'(kb_row_onehot_n(cur_row, ROWS));
    end

endmodule
